// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned N_REQ_DEF      = 4;
    localparam int unsigned DATA_WD_DEF    = 8;
    localparam int unsigned GAP_CYCLES_DEF = 2;
    localparam int unsigned GAP_W          = 4;

    // One-hot arbiter state encoding
    typedef enum logic [3:0] {
        ARB   = 4'b0001,
        START = 4'b0010,
        BUSY  = 4'b0100,
        GAP   = 4'b1000
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester + serializer handshake bundle seen by the arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned data_wd = DATA_WD_DEF
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]         req;
    logic [N_REQ*data_wd-1:0] din_bus;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         done;
    logic [IDX_W-1:0]         owner;
    logic                     arb_busy;
    logic                     tx_start;
    logic [data_wd-1:0]       tx_din;
    logic                     tx_busy;

    // Producers and serializer side
    modport master (
        output req, din_bus, tx_busy,
        input  gnt, done, owner, arb_busy, tx_start, tx_din
    );

    // Arbiter side
    modport slave (
        input  req, din_bus, tx_busy,
        output gnt, done, owner, arb_busy, tx_start, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search starting just above ptr.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             valid
);

    // First set request at ptr+1, ptr+2, ... wrapping; ptr itself is checked last
    always_comb begin
        int unsigned j;
        logic [IDX_W-1:0] jj;
        win_oh  = '0;
        win_idx = '0;
        valid   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            j  = (32'(ptr) + k) % N_REQ;
            jj = IDX_W'(j);
            if (!valid && req[jj]) begin
                valid   = 1'b1;
                win_idx = jj;
                win_oh  = N_REQ'(1) << jj;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx serializer among N_REQ producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned data_wd    = DATA_WD_DEF,
    parameter int unsigned gap_cycles = GAP_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [data_wd-1:0] data_q, data_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               tx_start_q, tx_start_d;
    logic               arb_busy_q, arb_busy_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [N_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .valid   (win_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ARB;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB:     if (win_valid)     state_d = START;
            START:   if (bus.tx_busy)   state_d = BUSY;
            BUSY:    if (!bus.tx_busy)  state_d = GAP;
            GAP:     if (gap_q == '0)   state_d = ARB;
            default:                    state_d = ARB;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        gnt_d      = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
        data_d     = data_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        gap_d      = gap_q;
        arb_busy_d = (state_d != ARB);
        unique case (state_q)
            ARB: begin
                if (win_valid) begin
                    gnt_d      = win_oh;
                    tx_start_d = 1'b1;
                    owner_d    = win_idx;
                    ptr_d      = win_idx;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (win_idx == IDX_W'(i)) data_d = bus.din_bus[i*data_wd +: data_wd];
                    end
                end
            end
            START: tx_start_d = !bus.tx_busy;
            BUSY: begin
                // tx_busy falling is the only frame-complete indication (tx_done is sticky)
                if (!bus.tx_busy) begin
                    done_d = N_REQ'(1) << owner_q;
                    gap_d  = GAP_W'(gap_cycles);
                end
            end
            GAP: if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q      <= IDX_W'(N_REQ - 1);
            owner_q    <= '0;
            data_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            arb_busy_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            data_q     <= data_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            arb_busy_q <= arb_busy_d;
            gap_q      <= gap_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.owner    = owner_q;
    assign bus.arb_busy = arb_busy_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_din   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural serializer model.
module tb_uart_tx_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned GAP = 2;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;

    uart_tx_arbiter_if #(.N_REQ(NR), .data_wd(DW)) bus ();

    uart_tx_arbiter #(.N_REQ(NR), .data_wd(DW), .gap_cycles(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    exp_t gnt_exp_q[$];
    int   done_exp_q[$];

    int cyc = 0;
    int extra_dly = 0;
    int busy_len = 10;
    int exp_start_w = 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Serializer model: busy rises extra_dly+1 edges after tx_start, lasts busy_len cycles
    initial begin
        logic start_s, rst_s;
        int wcnt, bcnt;
        bus.tx_busy = 1'b0;
        wcnt = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            start_s = bus.tx_start;
            rst_s   = rst;
            @(posedge clk);
            #1;
            if (!rst_s) begin
                bus.tx_busy = 1'b0;
                wcnt = 0;
                bcnt = 0;
            end else if (!bus.tx_busy) begin
                if (start_s) begin
                    if (wcnt == extra_dly) begin
                        bus.tx_busy = 1'b1;
                        bcnt = busy_len;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end else begin
                bcnt--;
                if (bcnt == 0) bus.tx_busy = 1'b0;
            end
        end
    end

    // Output monitor: pops grant/done expectations and checks timing
    initial begin
        exp_t e;
        int   di;
        logic prev_busy;
        int   fall_cyc, done_cyc, st_w;
        bit   have_done;
        logic [7:0] cur_byte;
        prev_busy = 1'b0;
        fall_cyc = 0;
        done_cyc = 0;
        st_w = 0;
        have_done = 1'b0;
        cur_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_busy = 1'b0;
                st_w = 0;
                have_done = 1'b0;
                cur_byte = 8'h00;
            end else begin
                if (prev_busy && !bus.tx_busy) fall_cyc = cyc;
                prev_busy = bus.tx_busy;

                if (bus.gnt != '0) begin
                    if (gnt_exp_q.size() == 0) begin
                        check_val("gnt_unexpected", 32'(bus.gnt), 32'd0);
                    end else begin
                        e = gnt_exp_q.pop_front();
                        check_val("gnt_onehot", 32'(bus.gnt), 32'(1) << e.idx);
                        check_val("gnt_tx_din", 32'(bus.tx_din), 32'(e.data));
                        check_val("gnt_tx_start", 32'(bus.tx_start), 32'd1);
                        check_val("gnt_owner", 32'(bus.owner), 32'(e.idx));
                        if (have_done) check_val("gap_min", 32'((cyc - done_cyc) >= int'(GAP + 1)), 32'd1);
                        cur_byte = e.data;
                        done_exp_q.push_back(e.idx);
                    end
                end

                if (bus.tx_busy) check_val("din_stable", 32'(bus.tx_din), 32'(cur_byte));

                if (bus.tx_start) begin
                    st_w++;
                end else if (st_w != 0) begin
                    check_val("start_width", 32'(st_w), 32'(exp_start_w));
                    st_w = 0;
                end

                if (bus.done != '0) begin
                    if (done_exp_q.size() == 0) begin
                        check_val("done_unexpected", 32'(bus.done), 32'd0);
                    end else begin
                        di = done_exp_q.pop_front();
                        check_val("done_onehot", 32'(bus.done), 32'(1) << di);
                        check_val("done_latency", 32'(cyc - fall_cyc), 32'd1);
                        done_cyc = cyc;
                        have_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.req = bus.req & ~bus.gnt;
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        bus.din_bus[i*DW +: DW] = b;
    endtask

    task automatic expect_grant(input int i, input logic [7:0] b);
        exp_t e;
        e.idx  = i;
        e.data = b;
        set_byte(i, b);
        gnt_exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        check_val({tag, "_done"}, 32'(bus.done), 32'd0);
        check_val({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check_val({tag, "_tx_din"}, 32'(bus.tx_din), 32'd0);
        check_val({tag, "_arb_busy"}, 32'(bus.arb_busy), 32'd0);
        check_val({tag, "_owner"}, 32'(bus.owner), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        done_exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_drained(input string tag);
        check_val({tag, "_pending"}, 32'(gnt_exp_q.size() + done_exp_q.size()), 32'd0);
        check_val({tag, "_idle"}, 32'(bus.arb_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        bus.req = '0;
        bus.din_bus = '0;

        // Reset state
        do_reset();

        // Single request
        expect_grant(0, 8'hA5);
        bus.req = 4'b0001;
        run_cycles(30);
        check_drained("single");

        // All four at once from a fresh pointer: 0,1,2,3
        do_reset();
        expect_grant(0, 8'h11);
        expect_grant(1, 8'h22);
        expect_grant(2, 8'h33);
        expect_grant(3, 8'h44);
        bus.req = 4'b1111;
        run_cycles(80);
        check_drained("all4");

        // Wrap fairness: 3 just served, 0 then 3
        expect_grant(0, 8'h5A);
        expect_grant(3, 8'hC3);
        bus.req = 4'b1001;
        run_cycles(40);
        check_drained("wrap");

        // Withdrawal of req[2] while requester 1 is on the wire
        expect_grant(1, 8'h77);
        set_byte(2, 8'h88);
        bus.req = 4'b0110;
        run_cycles(4);
        check_val("withdraw_in_busy", 32'(bus.arb_busy), 32'd1);
        bus.req[2] = 1'b0;
        run_cycles(30);
        check_drained("withdraw");
        check_val("withdraw_owner", 32'(bus.owner), 32'd1);

        // Slow serializer: tx_start stretched to 4 cycles
        extra_dly = 2;
        exp_start_w = 4;
        expect_grant(2, 8'h3C);
        bus.req = 4'b0100;
        run_cycles(40);
        check_drained("slow");
        extra_dly = 0;
        exp_start_w = 2;

        // Reset in the middle of a frame
        expect_grant(3, 8'h99);
        bus.req = 4'b1000;
        run_cycles(6);
        check_val("midrst_busy", 32'(bus.tx_busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        done_exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_grant(1, 8'h5E);
        bus.req = 4'b0010;
        @(posedge clk);
        #1;
        check_val("midrst_regrant", 32'(bus.gnt), 32'b0010);
        check_val("midrst_regrant_din", 32'(bus.tx_din), 32'h5E);
        bus.req = bus.req & ~bus.gnt;
        run_cycles(30);
        check_drained("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
